bitmap_row_scanner: RTL

- Reader for the 64-bit-wide, 6-bit-address combinational bitmap ROM.
- On a start request it walks ROM rows 0..ROWS-1, drives the ROM address and latches each row.
- It serialises each row MSB-first as a 1-bit pixel stream with valid/ready handshake and row/column/frame markers.
- It sits between the image ROM and a display or pixel sink.

---
 rtl/bitmap_pkg.sv | 9 +
 rtl/bitmap_row_scanner_if.sv | 14 +
 rtl/row_serializer.sv | 34 +++
 rtl/bitmap_row_scanner.sv | 59 +++++
 4 files changed

// File: rtl/bitmap_pkg.sv
// bitmap_pkg: shared scan geometry, FSM state encoding and ROM row type.
package bitmap_pkg;
    localparam int ROWS   = 48;
    localparam int COLS   = 64;
    localparam int ADDR_W = 6;
    localparam int COL_W  = 6;
    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} scan_state_t;
    typedef logic [COLS-1:0] row_t;
endpackage

// File: rtl/bitmap_row_scanner_if.sv
// bitmap_row_scanner_if: pixel stream with valid/ready handshake and frame markers.
interface bitmap_row_scanner_if;
    import bitmap_pkg::*;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_data;
    logic [ADDR_W-1:0] pix_row;
    logic [COL_W-1:0]  pix_col;
    logic              sof;
    logic              eol;
    logic              eof;
    modport master(output pix_valid, pix_data, pix_row, pix_col, sof, eol, eof, input pix_ready);
    modport slave(input pix_valid, pix_data, pix_row, pix_col, sof, eol, eof, output pix_ready);
endinterface

// File: rtl/row_serializer.sv
// row_serializer: loads one ROM row and shifts it out MSB-first, one pixel per transfer.
module row_serializer
    import bitmap_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             active,
    input  logic             ready,
    input  row_t             data,
    output logic             msb,
    output logic [COL_W-1:0] col,
    output logic             eol,
    output logic             xfer
);
    row_t shreg;
    always_comb begin
        xfer = active && ready;
        eol  = active && col == COL_W'(COLS-1);
        msb  = shreg[COLS-1];
    end
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            shreg <= '0;
            col   <= '0;
        end else if (load) begin
            shreg <= data;
        end else if (xfer) begin
            shreg <= {shreg[COLS-2:0], 1'b0};
            col   <= eol ? '0 : col + 1'b1;
        end
    end
endmodule

// File: rtl/bitmap_row_scanner.sv
// bitmap_row_scanner: walks the bitmap ROM row by row and streams its pixels.
module bitmap_row_scanner
    import bitmap_pkg::*;
#(
    parameter bit INVERT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [ADDR_W-1:0]    rom_addr,
    input  row_t                 rom_data,
    output logic                 busy,
    output logic                 done,
    bitmap_row_scanner_if.master pix
);
    scan_state_t       state, next_state;
    logic [ADDR_W-1:0] row;
    logic [COL_W-1:0]  col;
    logic              msb, eol, xfer, last_row;
    assign last_row = row == ADDR_W'(ROWS-1);
    row_serializer u_ser (
        .clk(clk), .rst_n(rst_n), .clr(abort || state == IDLE), .load(state == FETCH),
        .active(state == SHIFT), .ready(pix.pix_ready), .data(rom_data),
        .msb(msb), .col(col), .eol(eol), .xfer(xfer)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
        end else begin
            state <= next_state;
            if (abort || state == IDLE || state == DONE)
                row <= '0;
            else if (xfer && eol && !last_row)
                row <= row + 1'b1;
        end
    end
    // abort outranks every transition, including a start seen in IDLE
    always_comb begin
        next_state = abort           ? IDLE :
                     state == IDLE   ? (start ? FETCH : IDLE) :
                     state == FETCH  ? SHIFT :
                     state == SHIFT  ? ((xfer && eol) ? (last_row ? DONE : FETCH) : SHIFT) :
                                       IDLE;
    end
    always_comb begin
        rom_addr      = row;
        busy          = state != IDLE;
        done          = state == DONE;
        pix.pix_valid = state == SHIFT;
        pix.pix_data  = msb ^ INVERT;
        pix.pix_row   = row;
        pix.pix_col   = col;
        pix.sof       = state == SHIFT && row == '0 && col == '0;
        pix.eol       = eol;
        pix.eof       = eol && last_row;
    end
endmodule
